filter_sink_fifo: RTL



---
 rtl/filter_sink_fifo.sv | 91 +++++++++
 1 files changed

// File: rtl/filter_sink_fifo.sv
// Sink for the valid-only FilterBlock stream: buffers {parity, data} in a show-ahead FIFO,
// re-offers it on ready/valid, and counts words lost to overflow without back-pressuring upstream.
module filter_sink_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      io_x_data,
  input  logic                       io_x_valid,
  input  logic                       io_x_parity,
  output logic [DATA_WIDTH-1:0]      io_y_data,
  output logic                       io_y_parity,
  output logic                       io_y_valid,
  input  logic                       io_y_ready,
  output logic [$clog2(DEPTH):0]     io_count,
  output logic [CNT_WIDTH-1:0]       io_dropped,
  output logic                       io_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic                  parity;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t               mem [DEPTH];
  logic [AW-1:0]        rd_ptr_q;
  logic [AW-1:0]        wr_ptr_q;
  logic [CW-1:0]        count_q;
  logic [CNT_WIDTH-1:0] dropped_q;
  logic                 overflow_q;

  logic   not_empty_c;
  logic   full_c;
  logic   pop_c;
  logic   push_c;
  logic   drop_c;
  entry_t head_c;

  // Handshake decode; a full FIFO still accepts a word when the head leaves the same cycle.
  always_comb begin
    not_empty_c = (count_q != '0);
    full_c      = (count_q == CW'(DEPTH));
    pop_c       = not_empty_c & io_y_ready;
    push_c      = io_x_valid & (~full_c | pop_c);
    drop_c      = io_x_valid & ~push_c;
    head_c      = mem[rd_ptr_q];
  end

  // Payload storage carries no reset; validity comes from the occupancy counter.
  always_ff @(posedge clk) begin
    if (!reset && push_c) begin
      mem[wr_ptr_q] <= '{parity: io_x_parity, data: io_x_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      dropped_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop_c) begin
        overflow_q <= 1'b1;
        if (dropped_q != '1) dropped_q <= dropped_q + CNT_WIDTH'(1);
      end
    end
  end

  // Outputs derive from registered state only; head is masked to zero when empty.
  assign io_y_valid  = not_empty_c;
  assign io_y_data   = not_empty_c ? head_c.data : '0;
  assign io_y_parity = not_empty_c & head_c.parity;
  assign io_count    = count_q;
  assign io_dropped  = dropped_q;
  assign io_overflow = overflow_q;

endmodule
